// File: rtl/gpio_pkg.sv
// GPIO controller shared definitions: register map, register count, debounce constant.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gpio_pkg;

    // Word offsets of the registers relative to BASE_ADR
    localparam logic [3:0] REG_OUT      = 4'd0;
    localparam logic [3:0] REG_OUT_SET  = 4'd1;
    localparam logic [3:0] REG_OUT_CLR  = 4'd2;
    localparam logic [3:0] REG_IN       = 4'd3;
    localparam logic [3:0] REG_EN       = 4'd4;
    localparam logic [3:0] REG_IRQ_EN   = 4'd5;
    localparam logic [3:0] REG_RISE_EN  = 4'd6;
    localparam logic [3:0] REG_FALL_EN  = 4'd7;
    localparam logic [3:0] REG_IRQ_STAT = 4'd8;
    localparam logic [3:0] REG_DEB_DIV  = 4'd9;

    localparam int GPIO_REG_NUM = 10;

    // A pin's filtered value follows the synchronised value only after it
    // has been stable for this many prescaler ticks.
    localparam int DEB_STABLE_CNT = 3;

    // Word offset of a bus address from the block base; wraps below base so
    // that a single unsigned compare against GPIO_REG_NUM decides a hit.
    function automatic logic [13:0] reg_offset(input logic [13:0] adr, input logic [13:0] base);
        return adr - base;
    endfunction

endpackage

// File: rtl/gpio_if.sv
// DMA I/O bus slice seen by one peripheral: write port, read strobe, read-data daisy chain.
// Latency: n/a (wiring only).
// Backpressure: none; the bus has no stall, every strobe is accepted.
interface gpio_if;
    logic        dma_io_we;
    logic [13:0] dma_io_wadr;
    logic [31:0] dma_io_wdata;
    logic [13:0] dma_io_radr;
    logic        dma_io_radr_en;
    logic [31:0] dma_io_rdata_in;
    logic [31:0] dma_io_rdata;

    // Bus side: issues strobes, supplies upstream read data, receives chained read data
    modport master (
        output dma_io_we, dma_io_wadr, dma_io_wdata,
        output dma_io_radr, dma_io_radr_en, dma_io_rdata_in,
        input  dma_io_rdata
    );

    // Peripheral side
    modport slave (
        input  dma_io_we, dma_io_wadr, dma_io_wdata,
        input  dma_io_radr, dma_io_radr_en, dma_io_rdata_in,
        output dma_io_rdata
    );
endinterface

// File: rtl/gpio_pin_filter.sv
// One-pin input conditioner: SYNC_STG-flop synchroniser then filter flop (debounce with GPIO_DEBOUNCE_EN).
// Latency: SYNC_STG+1 clk without debounce; with debounce the value must be stable for 3 ticks.
// Backpressure: none.
module gpio_pin_filter
    import gpio_pkg::*;
#(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
`ifdef GPIO_DEBOUNCE_EN
    input  logic tick_i,
    input  logic clr_i,
`endif
    output logic filt_o
);

    logic [SYNC_STG-1:0] sync_q;
    logic                sync_val;
    logic                filt_q;

    // Metastability synchroniser for the asynchronous pad input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STG-2:0], pin_i};
    end

    assign sync_val = sync_q[SYNC_STG-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_STABLE_CNT);

    logic [CW-1:0] stab_q, stab_d;
    logic          filt_d;

    // Count ticks during which the synchronised value differs from the
    // filtered one; any cycle of agreement (a bounce back) restarts the count.
    always_comb begin
        stab_d = stab_q;
        filt_d = filt_q;
        if (clr_i || (sync_val == filt_q)) begin
            stab_d = '0;
        end else if (tick_i) begin
            if (stab_q == CW'(DEB_STABLE_CNT - 1)) begin
                filt_d = sync_val;
                stab_d = '0;
            end else begin
                stab_d = stab_q + CW'(1);
            end
        end
    end

    // Debounce state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_q <= '0;
            filt_q <= 1'b0;
        end else begin
            stab_q <= stab_d;
            filt_q <= filt_d;
        end
    end
`else
    // Without debounce the filter is a plain retiming flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) filt_q <= 1'b0;
        else        filt_q <= sync_val;
    end
`endif

    assign filt_o = filt_q;

endmodule

// File: rtl/gpio_ctrl.sv
// Parametrised GPIO controller on the DMA I/O bus: out/dir/set/clr, filtered input, edge irq.
// Latency: writes apply on the strobe edge; read data 1 clk after radr_en; gpio_i->IN SYNC_STG+1 clk.
// Backpressure: none; optional input debounce selected by macro GPIO_DEBOUNCE_EN.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int          GPIO_W   = 8,
    parameter logic [13:0] BASE_ADR = 14'h3F88,
    parameter int          SYNC_STG = 2,
    parameter int          DEB_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    gpio_if.slave             bus,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic [GPIO_W-1:0] gpio_en,
    output logic              irq
);

    logic [13:0]       woff, roff;
    logic              wr_hit, rd_hit;
    logic [3:0]        wsel, rsel;
    logic [GPIO_W-1:0] wd;

    logic [GPIO_W-1:0] out_q, out_d;
    logic [GPIO_W-1:0] en_q, en_d;
    logic [GPIO_W-1:0] irq_en_q, irq_en_d;
    logic [GPIO_W-1:0] rise_en_q, rise_en_d;
    logic [GPIO_W-1:0] fall_en_q, fall_en_d;
    logic [GPIO_W-1:0] irq_stat_q, irq_stat_d;
    logic [GPIO_W-1:0] in_w, in_prev_q, edge_set;
    logic [DEB_W-1:0]  deb_div_rd;

    logic [31:0]       rd_val;
    logic [31:0]       rd_data_q;
    logic              rd_hit_q;
    logic              unused_wdata;

    assign woff   = reg_offset(bus.dma_io_wadr, BASE_ADR);
    assign roff   = reg_offset(bus.dma_io_radr, BASE_ADR);
    assign wsel   = woff[3:0];
    assign rsel   = roff[3:0];
    assign wr_hit = bus.dma_io_we      && (woff < 14'(GPIO_REG_NUM));
    assign rd_hit = bus.dma_io_radr_en && (roff < 14'(GPIO_REG_NUM));
    assign wd     = bus.dma_io_wdata[GPIO_W-1:0];

    // Data bits above the pin count are write-ignored
    assign unused_wdata = ^bus.dma_io_wdata;

`ifdef GPIO_DEBOUNCE_EN
    logic [DEB_W-1:0] deb_div_q, deb_div_d;
    logic [DEB_W-1:0] presc_q;
    logic             deb_tick, deb_clr;

    assign deb_tick   = (presc_q == deb_div_q);
    assign deb_clr    = wr_hit && (wsel == REG_DEB_DIV);
    assign deb_div_rd = deb_div_q;

    // Shared prescaler: one tick every DEB_DIV+1 clocks, restarted by a DEB_DIV write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  presc_q <= '0;
        else if (deb_clr || deb_tick) presc_q <= '0;
        else                         presc_q <= presc_q + DEB_W'(1);
    end
`else
    assign deb_div_rd = '0;
`endif

    // Per-pin synchroniser and filter
    for (genvar g = 0; g < GPIO_W; g++) begin : g_pin
        gpio_pin_filter #(
            .SYNC_STG (SYNC_STG)
        ) u_filt (
            .clk    (clk),
            .rst_n  (rst_n),
            .pin_i  (gpio_i[g]),
`ifdef GPIO_DEBOUNCE_EN
            .tick_i (deb_tick),
            .clr_i  (deb_clr),
`endif
            .filt_o (in_w[g])
        );
    end

    assign edge_set = (in_w & ~in_prev_q & rise_en_q) | (~in_w & in_prev_q & fall_en_q);

    // Register file next state; an edge in the same cycle as a w1c keeps the status bit set
    always_comb begin
        out_d      = out_q;
        en_d       = en_q;
        irq_en_d   = irq_en_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        irq_stat_d = irq_stat_q | edge_set;
`ifdef GPIO_DEBOUNCE_EN
        deb_div_d  = deb_div_q;
`endif
        if (wr_hit) begin
            case (wsel)
                REG_OUT:      out_d      = wd;
                REG_OUT_SET:  out_d      = out_q | wd;
                REG_OUT_CLR:  out_d      = out_q & ~wd;
                REG_EN:       en_d       = wd;
                REG_IRQ_EN:   irq_en_d   = wd;
                REG_RISE_EN:  rise_en_d  = wd;
                REG_FALL_EN:  fall_en_d  = wd;
                REG_IRQ_STAT: irq_stat_d = (irq_stat_q & ~wd) | edge_set;
`ifdef GPIO_DEBOUNCE_EN
                REG_DEB_DIV:  deb_div_d  = bus.dma_io_wdata[DEB_W-1:0];
`endif
                default: ;
            endcase
        end
    end

    // Register file and input history state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            en_q       <= '0;
            irq_en_q   <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            irq_stat_q <= '0;
            in_prev_q  <= '0;
`ifdef GPIO_DEBOUNCE_EN
            deb_div_q  <= '0;
`endif
        end else begin
            out_q      <= out_d;
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            irq_stat_q <= irq_stat_d;
            in_prev_q  <= in_w;
`ifdef GPIO_DEBOUNCE_EN
            deb_div_q  <= deb_div_d;
`endif
        end
    end

    // Read-back mux; write-only strobes and unused high bits read as zero
    always_comb begin
        rd_val = '0;
        case (rsel)
            REG_OUT:      rd_val[GPIO_W-1:0] = out_q;
            REG_IN:       rd_val[GPIO_W-1:0] = in_w;
            REG_EN:       rd_val[GPIO_W-1:0] = en_q;
            REG_IRQ_EN:   rd_val[GPIO_W-1:0] = irq_en_q;
            REG_RISE_EN:  rd_val[GPIO_W-1:0] = rise_en_q;
            REG_FALL_EN:  rd_val[GPIO_W-1:0] = fall_en_q;
            REG_IRQ_STAT: rd_val[GPIO_W-1:0] = irq_stat_q;
            REG_DEB_DIV:  rd_val[DEB_W-1:0]  = deb_div_rd;
            default: ;
        endcase
    end

    // Capture the read hit and its data for the following cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_hit_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_hit_q <= rd_hit;
            if (rd_hit) rd_data_q <= rd_val;
        end
    end

    assign bus.dma_io_rdata = rd_hit_q ? rd_data_q : bus.dma_io_rdata_in;
    assign gpio_o           = out_q;
    assign gpio_en          = en_q;
    assign irq              = |(irq_stat_q & irq_en_q);

endmodule
